// File: rtl/jt6295_pkg.sv
// jt6295_pkg: constants shared across the JT6295 sound datapath.
package jt6295_pkg;
    localparam int JT6295_SND_W = 12;
endpackage

// File: rtl/jt6295_delay_line_if.sv
// jt6295_delay_line_if: data port of a delay line (enable, word in, oldest word out).
interface jt6295_delay_line_if #(parameter int WIDTH = 1);
    logic             clk_en;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] drop;
    modport master(output clk_en, din, input drop);
    modport slave(input clk_en, din, output drop);
endinterface

// File: rtl/jt6295_delay_stage.sv
// jt6295_delay_stage: one WIDTH-bit register with asynchronous clear and enable.
module jt6295_delay_stage #(parameter int WIDTH = 1) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] q_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) q_q <= '0;
        else if (en_i) q_q <= d_i;
    assign q_o = q_q;
endmodule

// File: rtl/jt6295_delay_line.sv
// jt6295_delay_line: delays a WIDTH-bit word by STAGES enabled clock cycles.
// Define JT6295_SH_CHECK_EN to compile in parameter and X/Z input checks for simulation.
module jt6295_delay_line
    import jt6295_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input logic clk,
    input logic rst,
    jt6295_delay_line_if.slave bus
);
    logic [WIDTH-1:0] stage_q [STAGES];
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            jt6295_delay_stage #(.WIDTH(WIDTH)) u_stage (
                .clk(clk), .rst(rst), .en_i(bus.clk_en), .d_i(bus.din), .q_o(stage_q[k])
            );
        end else begin : g_body
            jt6295_delay_stage #(.WIDTH(WIDTH)) u_stage (
                .clk(clk), .rst(rst), .en_i(bus.clk_en), .d_i(stage_q[k-1]), .q_o(stage_q[k])
            );
        end
    end
    assign bus.drop = stage_q[STAGES-1];
`ifdef JT6295_SH_CHECK_EN
    initial if (WIDTH < 1 || STAGES < 1) $fatal(1, "jt6295_delay_line: WIDTH=%0d STAGES=%0d illegal", WIDTH, STAGES);
    always @(posedge clk)
        if (!rst && bus.clk_en && $isunknown(bus.din)) $warning("jt6295_delay_line: din has X/Z (%b)", bus.din);
`else
`endif
endmodule

// File: tb/tb_jt6295_delay_line.sv
// tb_jt6295_delay_line: vector table, corner sequences and random checks on three delay-line shapes.
module tb_jt6295_delay_line;
    import jt6295_pkg::*;
    localparam int WA = JT6295_SND_W, SA = 4, SB = 1, WC = 4, SC = 5;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    jt6295_delay_line_if #(.WIDTH(WA)) ia ();
    jt6295_delay_line_if #(.WIDTH(1))  ib ();
    jt6295_delay_line_if #(.WIDTH(WC)) ic ();

    jt6295_delay_line #(.WIDTH(WA), .STAGES(SA)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    jt6295_delay_line #(.WIDTH(1),  .STAGES(SB)) dut_b (.clk(clk), .rst(rst), .bus(ib));
    jt6295_delay_line #(.WIDTH(WC), .STAGES(SC)) dut_c (.clk(clk), .rst(rst), .bus(ic));

    typedef struct {
        logic        r;
        logic        en;
        logic [11:0] din;
        logic [11:0] exp;
    } vec_t;
    vec_t tv[$];

    int n_cmp = 0, n_err = 0;
    logic [11:0] ha[$], hb[$], hc[$];

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: keep the last STAGES accepted words; the oldest one is on drop once the line is full.
    function automatic logic [11:0] oldest(input logic [11:0] h[$], input int st);
        return (h.size() == st) ? h[0] : 12'h0;
    endfunction

    task automatic hist(inout logic [11:0] h[$], input logic en, input logic [11:0] d, input int st);
        if (rst) h.delete();
        else if (en) begin
            h.push_back(d);
            if (h.size() > st) void'(h.pop_front());
        end
    endtask

    task automatic cyc(input logic r, input logic ea, input logic [11:0] da,
                       input logic eb, input logic db, input logic ec, input logic [3:0] dc);
        rst = r;
        ia.clk_en = ea; ia.din = da;
        ib.clk_en = eb; ib.din = db;
        ic.clk_en = ec; ic.din = dc;
        @(posedge clk);
        #1;
        hist(ha, ea, da, SA);
        hist(hb, eb, {11'b0, db}, SB);
        hist(hc, ec, {8'b0, dc}, SC);
        chk("model_a", ia.drop, oldest(ha, SA));
        chk("model_b", {11'b0, ib.drop}, oldest(hb, SB));
        chk("model_c", {8'b0, ic.drop}, oldest(hc, SC));
    endtask

    task automatic add(input logic r, input logic en, input logic [11:0] d, input logic [11:0] e);
        vec_t v;
        v.r = r; v.en = en; v.din = d; v.exp = e;
        tv.push_back(v);
    endtask

    initial begin
        ia.clk_en = 1'b1; ia.din = 12'hABC;
        ib.clk_en = 1'b1; ib.din = 1'b1;
        ic.clk_en = 1'b1; ic.din = 4'hF;
        #1;
        chk("reset_t0_a", ia.drop, 12'h0);
        chk("reset_t0_c", {8'b0, ic.drop}, 12'h0);

        for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 12'hABC, 12'h0);
        for (int i = 1; i <= 8; i++) add(1'b0, 1'b1, (i <= 5) ? 12'(i) : 12'h0, (i >= 4) ? 12'(i - 3) : 12'h0);
        for (int g = 0; g < 5; g++) begin
            logic [11:0] hold, after;
            hold  = (g == 0) ? 12'd5 : (g == 4) ? 12'd7 : 12'd0;
            after = (g == 3) ? 12'd7 : (g == 4) ? 12'd8 : 12'd0;
            for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 12'hFFF, hold);
            add(1'b0, 1'b1, 12'(7 + g), after);
        end
        foreach (tv[i]) begin
            cyc(tv[i].r, tv[i].en, tv[i].din, 1'b0, 1'b0, 1'b0, 4'h0);
            chk($sformatf("vec%0d", i), ia.drop, tv[i].exp);
        end

        // Asynchronous reset pulse between edges with the line full of 11,10,9,8.
        #2 rst = 1'b1;
        #1;
        chk("async_rst_a", ia.drop, 12'h0);
        ha.delete(); hb.delete(); hc.delete();
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 12'(12'h100 + i), 1'b0, 1'b0, 1'b0, 4'h0);
            chk($sformatf("refill%0d", i), ia.drop, (i == 3) ? 12'h100 : 12'h0);
        end

        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b0, 12'h0, 1'b1, 1'(i + 1), 1'b0, 4'h0);
            chk($sformatf("depth1_%0d", i), {11'b0, ib.drop}, 12'((i + 1) % 2));
        end

        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b0, 12'h0, 1'b0, 1'b0, 1'b1, (i == 0) ? 4'h9 : 4'h0);
            chk($sformatf("depth5_%0d", i), {8'b0, ic.drop}, (i == 4) ? 12'h9 : 12'h0);
        end

        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 49) == 0, 1'($urandom), 12'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
